spi_status_tx: RTL

- SPI-slave transmit side of the MCU link: returns a fixed 64-bit status frame on MISO while the MCU clocks a transaction.
- The frame is sent LSB-first, matching the bit order of the FPGA-side config receiver, so the MCU decodes both directions identically.
- Runs entirely in the system clock domain; SPI pins are oversampled, never used as clocks.
- Sits beside the config receiver on the shared spi_clk/spi_csn pins and feeds the MCU voice/clip/health feedback.

---
 rtl/protocol_pkg.sv | 38 +++
 rtl/spi_pin_sync.sv | 59 +++++
 rtl/spi_status_tx.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/protocol_pkg.sv
// Shared MCU-link protocol definitions: status frame layout, constants and
// the optional CRC-8 helper. STATUS_CRC8_EN builds the CRC function.
package protocol_pkg;

  localparam int         STATUS_FRAME_BITS = 64;
  localparam logic [7:0] STATUS_MAGIC      = 8'hA5;

  // Packed MSB-first, so magic lands in bits [7:0] and is shifted out first.
  typedef struct packed {
    logic [7:0]  crc;
    logic [7:0]  flags;
    logic [31:0] status;
    logic [7:0]  seq;
    logic [7:0]  magic;
  } status_frame_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } tx_state_e;

`ifdef STATUS_CRC8_EN
  // CRC-8, poly 0x07, init 0, no reflection; byte 0 first, each byte MSB-first.
  function automatic logic [7:0] crc8_07(input logic [55:0] data);
    logic [7:0] crc;
    crc = 8'h00;
    for (int b = 0; b < 7; b++) begin
      crc = crc ^ data[8*b +: 8];
      for (int i = 0; i < 8; i++) begin
        crc = crc[7] ? ({crc[6:0], 1'b0} ^ 8'h07) : {crc[6:0], 1'b0};
      end
    end
    return crc;
  endfunction
`endif

endpackage

// File: rtl/spi_pin_sync.sv
// Oversampling synchroniser and edge detector for the raw SPI pins.
// Edge pulses are registered, giving SYNC_STAGES+1 cycles pin-to-event.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic spi_clk,
  input  logic spi_csn,
  output logic csn_fall,
  output logic csn_rise,
  output logic sclk_fall
);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] csn_sync_q, csn_sync_d;
  logic                   sclk_hist_q, sclk_hist_d;
  logic                   csn_hist_q, csn_hist_d;
  logic                   csn_fall_q, csn_fall_d;
  logic                   csn_rise_q, csn_rise_d;
  logic                   sclk_fall_q, sclk_fall_d;

  // Shift chains, history taps and edge compares.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
    csn_sync_d  = {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
    sclk_hist_d = sclk_sync_q[SYNC_STAGES-1];
    csn_hist_d  = csn_sync_q[SYNC_STAGES-1];
    sclk_fall_d = sclk_hist_q & ~sclk_sync_q[SYNC_STAGES-1];
    csn_fall_d  = csn_hist_q & ~csn_sync_q[SYNC_STAGES-1];
    csn_rise_d  = ~csn_hist_q & csn_sync_q[SYNC_STAGES-1];
  end

  // csn chain resets high (deselected) so reset release never fakes a fall.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_sync_q <= '0;
      csn_sync_q  <= '1;
      sclk_hist_q <= 1'b0;
      csn_hist_q  <= 1'b1;
      sclk_fall_q <= 1'b0;
      csn_fall_q  <= 1'b0;
      csn_rise_q  <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      csn_sync_q  <= csn_sync_d;
      sclk_hist_q <= sclk_hist_d;
      csn_hist_q  <= csn_hist_d;
      sclk_fall_q <= sclk_fall_d;
      csn_fall_q  <= csn_fall_d;
      csn_rise_q  <= csn_rise_d;
    end
  end

  assign csn_fall  = csn_fall_q;
  assign csn_rise  = csn_rise_q;
  assign sclk_fall = sclk_fall_q;

endmodule

// File: rtl/spi_status_tx.sv
// SPI-slave status frame transmitter, LSB-first, mode 0, clk_sys domain.
// Optional STATUS_CRC8_EN fills byte 7 with a CRC-8/0x07; otherwise 8'h00.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | deselected, MISO tri-stated (oe=0), waiting for csn fall
//   ST_LOAD  | one cycle: snapshot frame, present bit 0
//   ST_SHIFT | shift on each sclk fall; csn rise ends the frame
module spi_status_tx
  import protocol_pkg::*;
#(
  parameter int         FRAME_BITS  = STATUS_FRAME_BITS,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] MAGIC       = STATUS_MAGIC
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        spi_clk,
  input  logic        spi_csn,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  input  logic [31:0] status_word,
  input  logic [7:0]  flag_set,
  output logic [7:0]  flags,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_abort
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);

  logic csn_fall, csn_rise, sclk_fall;

  tx_state_e              state_q, state_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [7:0]             seq_q, seq_d;
  logic [7:0]             flags_q, flags_d;
  logic [7:0]             clr_q, clr_d;
  logic                   frame_done_q, frame_done_d;
  logic                   frame_abort_q, frame_abort_d;
  status_frame_t          frame_w;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
    .clk       (clk),
    .rstn      (rstn),
    .spi_clk   (spi_clk),
    .spi_csn   (spi_csn),
    .csn_fall  (csn_fall),
    .csn_rise  (csn_rise),
    .sclk_fall (sclk_fall)
  );

  // Frame image built from live inputs; only latched during ST_LOAD.
  always_comb begin
    frame_w        = '0;
    frame_w.magic  = MAGIC;
    frame_w.seq    = seq_q;
    frame_w.status = status_word;
    frame_w.flags  = flags_q;
`ifdef STATUS_CRC8_EN
    frame_w.crc    = crc8_07({flags_q, status_word, seq_q, MAGIC});
`else
    frame_w.crc    = 8'h00;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; csn rise always wins and returns to idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (csn_fall) state_d = ST_LOAD;
      ST_LOAD:  state_d = csn_rise ? ST_IDLE : ST_SHIFT;
      ST_SHIFT: if (csn_rise) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Pin outputs and end-of-frame pulse requests.
  always_comb begin
    spi_miso      = 1'b0;
    spi_miso_oe   = 1'b0;
    busy          = 1'b0;
    frame_done_d  = 1'b0;
    frame_abort_d = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        spi_miso      = frame_w[0];
        spi_miso_oe   = 1'b1;
        busy          = 1'b1;
        frame_abort_d = csn_rise;
      end
      ST_SHIFT: begin
        spi_miso    = shift_q[0];
        spi_miso_oe = ~csn_rise;
        busy        = ~csn_rise;
        if (csn_rise) begin
          // The trailing fall after bit 63 is optional, so 63 already counts.
          if (cnt_q >= CNT_W'(FRAME_BITS - 1)) frame_done_d  = 1'b1;
          else                                 frame_abort_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath next values: shifter, bit counter, seq and sticky flags.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    clr_d   = clr_q;
    seq_d   = seq_q + {7'd0, frame_done_q};
    // Set is OR'd after the clear so a same-cycle set survives.
    flags_d = (flags_q & ~(frame_done_q ? clr_q : 8'h00)) | flag_set;
    unique case (state_q)
      ST_LOAD: begin
        shift_d = frame_w;
        cnt_d   = '0;
        clr_d   = flags_q;
      end
      ST_SHIFT: begin
        if (sclk_fall && !csn_rise) begin
          // Zero fill makes MISO pad with 0 once all bits are out.
          shift_d = {1'b0, shift_q[FRAME_BITS-1:1]};
          if (cnt_q != CNT_W'(FRAME_BITS)) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_q       <= '0;
      cnt_q         <= '0;
      seq_q         <= '0;
      flags_q       <= '0;
      clr_q         <= '0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      seq_q         <= seq_d;
      flags_q       <= flags_d;
      clr_q         <= clr_d;
      frame_done_q  <= frame_done_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  assign flags       = flags_q;
  assign frame_done  = frame_done_q;
  assign frame_abort = frame_abort_q;

endmodule
